// File: rtl/ui_multi_debouncer.sv
// ============================================================================
//  Module   : ui_multi_debouncer
//  Purpose  : N-channel debouncer / edge detector for active-low buttons.
//             Optional auto-repeat is enabled by defining UI_DEBOUNCE_REPEAT_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ui_multi_debouncer #(
    parameter int NUM_CH        = 4,
    parameter int STABLE_CYCLES = 50000,
    parameter int HOLD_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 5000000
) (
    input  logic              clock_50Mhz,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] raw_in_n,
    output logic [NUM_CH-1:0] level_n,
    output logic [NUM_CH-1:0] press_pulse,
    output logic [NUM_CH-1:0] release_pulse,
    output logic [NUM_CH-1:0] repeat_pulse,
    output logic              any_pressed
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

    localparam logic [CNT_W-1:0] c_CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RELEASED     = 2'd0,
        ST_PRESS_PEND   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_PEND = 2'd3
    } state_t;

    // Elaboration-time sanity checks on the configuration.
    if (STABLE_CYCLES < 2) begin : g_bad_stable
        $error("STABLE_CYCLES must be at least 2");
    end
    if ((HOLD_CYCLES < 1) || (REPEAT_CYCLES < 1) || (REPEAT_CYCLES > HOLD_CYCLES)) begin : g_bad_repeat
        $error("auto-repeat timing requires 1 <= REPEAT_CYCLES <= HOLD_CYCLES");
    end

    logic [NUM_CH-1:0] w_level_d_all;
    logic              r_any_q;
    logic              w_any_d;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [1:0]       r_sync_q;
        logic [1:0]       w_sync_d;
        logic             w_s;
        state_t           r_state_q;
        state_t           w_state_d;
        logic [CNT_W-1:0] r_cnt_q;
        logic [CNT_W-1:0] w_cnt_d;
        logic             r_level_q;
        logic             w_level_d;
        logic             r_press_q;
        logic             w_press_d;
        logic             r_release_q;
        logic             w_release_d;

        assign w_sync_d = {r_sync_q[0], raw_in_n[gi]};
        assign w_s      = r_sync_q[1];

        always_ff @(posedge clock_50Mhz or negedge reset_n) begin
            if (!reset_n) begin
                r_sync_q    <= 2'b11;
                r_state_q   <= ST_RELEASED;
                r_cnt_q     <= c_CNT_ZERO;
                r_level_q   <= 1'b1;
                r_press_q   <= 1'b0;
                r_release_q <= 1'b0;
            end else begin
                r_sync_q    <= w_sync_d;
                r_state_q   <= w_state_d;
                r_cnt_q     <= w_cnt_d;
                r_level_q   <= w_level_d;
                r_press_q   <= w_press_d;
                r_release_q <= w_release_d;
            end
        end

        // Counter tracks consecutive synced cycles that disagree with the level.
        always_comb begin
            w_state_d   = r_state_q;
            w_cnt_d     = r_cnt_q;
            w_level_d   = r_level_q;
            w_press_d   = 1'b0;
            w_release_d = 1'b0;
            case (r_state_q)
                ST_RELEASED: begin
                    if (!w_s) begin
                        w_state_d = ST_PRESS_PEND;
                        w_cnt_d   = c_CNT_ONE;
                    end else begin
                        w_cnt_d   = c_CNT_ZERO;
                    end
                end
                ST_PRESS_PEND: begin
                    if (w_s) begin
                        w_state_d = ST_RELEASED;
                        w_cnt_d   = c_CNT_ZERO;
                    end else if (r_cnt_q == c_CNT_LAST) begin
                        w_state_d = ST_PRESSED;
                        w_cnt_d   = c_CNT_ZERO;
                        w_level_d = 1'b0;
                        w_press_d = 1'b1;
                    end else begin
                        w_cnt_d   = r_cnt_q + c_CNT_ONE;
                    end
                end
                ST_PRESSED: begin
                    if (w_s) begin
                        w_state_d = ST_RELEASE_PEND;
                        w_cnt_d   = c_CNT_ONE;
                    end else begin
                        w_cnt_d   = c_CNT_ZERO;
                    end
                end
                ST_RELEASE_PEND: begin
                    if (!w_s) begin
                        w_state_d   = ST_PRESSED;
                        w_cnt_d     = c_CNT_ZERO;
                    end else if (r_cnt_q == c_CNT_LAST) begin
                        w_state_d   = ST_RELEASED;
                        w_cnt_d     = c_CNT_ZERO;
                        w_level_d   = 1'b1;
                        w_release_d = 1'b1;
                    end else begin
                        w_cnt_d     = r_cnt_q + c_CNT_ONE;
                    end
                end
                default: begin
                    w_state_d = ST_RELEASED;
                    w_cnt_d   = c_CNT_ZERO;
                    w_level_d = 1'b1;
                end
            endcase
        end

`ifdef UI_DEBOUNCE_REPEAT_EN
        localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

        logic [HOLD_W-1:0] r_hold_q;
        logic [HOLD_W-1:0] w_hold_d;
        logic              r_rep_q;
        logic              w_rep_d;

        always_ff @(posedge clock_50Mhz or negedge reset_n) begin
            if (!reset_n) begin
                r_hold_q <= '0;
                r_rep_q  <= 1'b0;
            end else begin
                r_hold_q <= w_hold_d;
                r_rep_q  <= w_rep_d;
            end
        end

        // After each repeat the counter rewinds by REPEAT_CYCLES, so the next
        // terminal count arrives exactly one repeat interval later.
        always_comb begin
            w_hold_d = r_hold_q;
            w_rep_d  = 1'b0;
            if (w_press_d) begin
                w_hold_d = '0;
            end else if (((r_state_q == ST_PRESSED) || (r_state_q == ST_RELEASE_PEND))
                         && !w_release_d) begin
                if (r_hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
                    w_rep_d  = 1'b1;
                    w_hold_d = HOLD_W'(HOLD_CYCLES - REPEAT_CYCLES);
                end else begin
                    w_hold_d = r_hold_q + HOLD_W'(1);
                end
            end
        end

        assign repeat_pulse[gi] = r_rep_q;
`else
        assign repeat_pulse[gi] = 1'b0;
`endif

        assign w_level_d_all[gi] = w_level_d;
        assign level_n[gi]       = r_level_q;
        assign press_pulse[gi]   = r_press_q;
        assign release_pulse[gi] = r_release_q;
    end

    // Registered alongside level_n so it changes in the very same cycle.
    assign w_any_d = |(~w_level_d_all);

    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_any_q <= 1'b0;
        end else begin
            r_any_q <= w_any_d;
        end
    end

    assign any_pressed = r_any_q;

endmodule

`default_nettype wire

// File: tb/tb_ui_multi_debouncer.sv
// ============================================================================
//  Module   : tb_ui_multi_debouncer
//  Purpose  : Directed bench for ui_multi_debouncer with a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ui_multi_debouncer;

    localparam int NUM_CH = 4;
    localparam int STABLE = 8;
    localparam int HOLD   = 40;
    localparam int REP    = 10;
`ifdef UI_DEBOUNCE_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic [NUM_CH-1:0] raw   = '1;
    wire  [NUM_CH-1:0] level_n;
    wire  [NUM_CH-1:0] press_pulse;
    wire  [NUM_CH-1:0] release_pulse;
    wire  [NUM_CH-1:0] repeat_pulse;
    wire               any_pressed;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ui_multi_debouncer #(
        .NUM_CH        (NUM_CH),
        .STABLE_CYCLES (STABLE),
        .HOLD_CYCLES   (HOLD),
        .REPEAT_CYCLES (REP)
    ) dut (
        .clock_50Mhz   (clk),
        .reset_n       (rst_n),
        .raw_in_n      (raw),
        .level_n       (level_n),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .repeat_pulse  (repeat_pulse),
        .any_pressed   (any_pressed)
    );

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
        end
    endtask

    // Model: input seen two edges late; level flips once the seen input has
    // disagreed with it for STABLE consecutive edges.
    logic [3:0] m_level, m_press, m_rel, m_rep;
    logic       m_any;
    logic [3:0] h1, h2, s;
    int         run  [NUM_CH];
    int         held [NUM_CH];
    logic       prev;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_level = '1; m_press = '0; m_rel = '0; m_rep = '0; m_any = 1'b0;
            h1 = '1; h2 = '1;
            for (int i = 0; i < NUM_CH; i++) begin run[i] = 0; held[i] = 0; end
        end else begin
            s  = h2;
            h2 = h1;
            h1 = raw;
            m_press = '0; m_rel = '0; m_rep = '0;
            for (int i = 0; i < NUM_CH; i++) begin
                prev = m_level[i];
                run[i] = (s[i] != m_level[i]) ? run[i] + 1 : 0;
                if (run[i] == STABLE) begin
                    run[i]     = 0;
                    m_level[i] = ~m_level[i];
                    if (m_level[i] == 1'b0) begin m_press[i] = 1'b1; held[i] = 0; end
                    else                          m_rel[i]   = 1'b1;
                end else if (!prev) begin
                    held[i]++;
                    if (REP_EN && held[i] >= HOLD && ((held[i] - HOLD) % REP) == 0)
                        m_rep[i] = 1'b1;
                end
            end
            m_any = |(~m_level);
        end
    end

    always @(negedge clk) begin
        chk("cyc_level_n", level_n, m_level);
        chk("cyc_press",   press_pulse, m_press);
        chk("cyc_release", release_pulse, m_rel);
        chk("cyc_repeat",  repeat_pulse, m_rep);
        chk("cyc_any",     {3'b000, any_pressed}, {3'b000, m_any});
    end

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        edges(1);
        chk("reset_level", level_n, 4'hF);
        chk("reset_press", press_pulse, 4'h0);
        chk("reset_any",   {3'b000, any_pressed}, 4'h0);

        // 1: single press, exact 10-edge latency, one-cycle pulse
        @(negedge clk); raw[0] = 1'b0;
        edges(9);
        chk("t1_early_level", level_n, 4'hF);
        edges(1);
        chk("t1_level", level_n, 4'b1110);
        chk("t1_press", press_pulse, 4'b0001);
        chk("t1_any",   {3'b000, any_pressed}, 4'h1);
        edges(1);
        chk("t1_pulse_width", press_pulse, 4'h0);

        // 2: short low pulse is rejected
        @(negedge clk); raw[1] = 1'b0;
        repeat (5) @(negedge clk); raw[1] = 1'b1;
        edges(15);
        chk("t2_level", level_n, 4'b1110);

        // 3: glitch while pressed, then clean release
        @(negedge clk); raw[2] = 1'b0;
        repeat (12) @(negedge clk);
        chk("t3_pressed", level_n, 4'b1010);
        raw[2] = 1'b1;
        repeat (3) @(negedge clk); raw[2] = 1'b0;
        repeat (15) @(negedge clk);
        chk("t3_glitch_level", level_n, 4'b1010);
        raw[2] = 1'b1;
        edges(9);
        chk("t3_early_level", level_n, 4'b1010);
        edges(1);
        chk("t3_level",   level_n, 4'b1110);
        chk("t3_release", release_pulse, 4'b0100);

        // 4: simultaneous presses on ch0 and ch3
        @(negedge clk); raw[0] = 1'b1;
        repeat (12) @(negedge clk);
        chk("t4_idle", level_n, 4'hF);
        raw[0] = 1'b0; raw[3] = 1'b0;
        edges(10);
        chk("t4_press", press_pulse, 4'b1001);
        chk("t4_level", level_n, 4'b0110);
        @(negedge clk); raw[0] = 1'b1;
        repeat (12) @(negedge clk);
        chk("t4_any_one_left", {3'b000, any_pressed}, 4'h1);
        raw[3] = 1'b1;
        edges(10);
        chk("t4_release", release_pulse, 4'b1000);
        chk("t4_any_off", {3'b000, any_pressed}, 4'h0);

        // 5: reset in the middle of a press count
        @(negedge clk); raw[1] = 1'b0;
        edges(8);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_level", level_n, 4'hF);
        chk("t5_rst_press", press_pulse, 4'h0);
        chk("t5_rst_any",   {3'b000, any_pressed}, 4'h0);
        @(negedge clk); rst_n = 1'b1;
        edges(9);
        chk("t5_early_level", level_n, 4'hF);
        edges(1);
        chk("t5_press", press_pulse, 4'b0010);

        // 6: auto-repeat while ch1 stays held
        for (int k = 1; k <= 65; k++) begin
            edges(1);
            chk("t6_repeat", repeat_pulse,
                (REP_EN && k >= HOLD && ((k - HOLD) % REP) == 0) ? 4'b0010 : 4'b0000);
        end
        @(negedge clk); raw[1] = 1'b1;
        edges(25);
        chk("t6_released", level_n, 4'hF);
        chk("t6_no_repeat", repeat_pulse, 4'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
